ssd_display_arbiter: RTL

- Shares the 8-digit seven-segment display between NUM_REQ requesters, such as UART RX byte, TX byte and status/error code.
- Grants one requester at a time, round-robin, with a guaranteed minimum dwell time per grant.
- Registers the granted requester's digits, blank mask and decimal points.
- Outputs feed the existing eight-digit display driver directly: hex_out[4k+3:4k] drives digit k, plus blank and dec_points.

---
 rtl/ssd_display_arbiter.sv | 116 +++++++++++
 1 files changed

// File: rtl/ssd_display_arbiter.sv
// ssd_display_arbiter: round-robin sharing of the 8-digit seven-segment display
// between NUM_REQ requesters, with a minimum dwell per grant and registered outputs.
module ssd_display_arbiter #(
  parameter int NUM_REQ      = 3,
  parameter int DWELL_CYCLES = 100_000_000
) (
  input  logic                   CLOCK_100,
  input  logic                   reset,
  input  logic [NUM_REQ-1:0]     req,
  input  logic [NUM_REQ*32-1:0]  req_hex,
  input  logic [NUM_REQ*8-1:0]   req_blank,
  input  logic [NUM_REQ*8-1:0]   req_dp,
  output logic [NUM_REQ-1:0]     grant,
  output logic [31:0]            hex_out,
  output logic [7:0]             blank_out,
  output logic [7:0]             dp_out,
  output logic                   busy
);
  localparam int PW = $clog2(NUM_REQ);
  localparam int CW = DWELL_CYCLES > 1 ? $clog2(DWELL_CYCLES) : 1;
  localparam logic [CW-1:0] CNT_MAX = CW'(DWELL_CYCLES - 1);
  typedef enum logic {IDLE = 1'b0, SHOW = 1'b1} state_t;
  state_t state_q, state_d;
  logic [NUM_REQ-1:0] grant_q, grant_d;
  logic [PW-1:0] last_q, last_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic [31:0] hex_q, hex_d, cur_hex;
  logic [7:0] blank_q, blank_d, dp_q, dp_d, cur_blank, cur_dp;
  logic cur_req;
  logic [PW:0] pick_all, pick_oth;
  // Returns {found, index}: first set bit of m searching upward from from+1 with wrap.
  function automatic logic [PW:0] rr_pick(input logic [NUM_REQ-1:0] m, input logic [PW-1:0] from);
    logic [PW:0] r;
    logic [PW-1:0] idx;
    r = '0;
    for (int k = NUM_REQ; k >= 1; k--) begin
      idx = PW'((int'(from) + k) % NUM_REQ);
      if (m[idx]) r = {1'b1, idx};
    end
    return r;
  endfunction
  always_comb begin
    cur_hex   = '0;
    cur_blank = '0;
    cur_dp    = '0;
    cur_req   = 1'b0;
    for (int i = 0; i < NUM_REQ; i++)
      if (last_q == PW'(i)) begin
        cur_hex   = req_hex[32*i +: 32];
        cur_blank = req_blank[8*i +: 8];
        cur_dp    = req_dp[8*i +: 8];
        cur_req   = req[i];
      end
    pick_all = rr_pick(req, last_q);
    pick_oth = rr_pick(req & ~grant_q, last_q);
    state_d  = state_q;
    grant_d  = grant_q;
    last_d   = last_q;
    cnt_d    = cnt_q;
    hex_d    = hex_q;
    blank_d  = blank_q;
    dp_d     = dp_q;
    if (state_q == IDLE) begin
      blank_d = 8'hFF;
      dp_d    = 8'h00;
      if (pick_all[PW]) begin
        state_d = SHOW;
        grant_d = NUM_REQ'(1) << pick_all[PW-1:0];
        last_d  = pick_all[PW-1:0];
        cnt_d   = '0;
      end
    end else if (!cur_req && !pick_oth[PW]) begin
      state_d = IDLE;
      grant_d = '0;
      cnt_d   = '0;
      blank_d = 8'hFF;
      dp_d    = 8'h00;
    end else begin
      hex_d   = cur_hex;
      blank_d = cur_blank;
      dp_d    = cur_dp;
      // A release or an expired dwell with someone waiting hands over without a dark cycle.
      if (!cur_req || (cnt_q == CNT_MAX && pick_oth[PW])) begin
        grant_d = NUM_REQ'(1) << pick_oth[PW-1:0];
        last_d  = pick_oth[PW-1:0];
        cnt_d   = '0;
      end else if (cnt_q != CNT_MAX) begin
        cnt_d = cnt_q + 1'b1;
      end
    end
  end
  always_ff @(posedge CLOCK_100 or posedge reset) begin
    if (reset) begin
      state_q <= IDLE;
      grant_q <= '0;
      last_q  <= PW'(NUM_REQ - 1);
      cnt_q   <= '0;
      hex_q   <= '0;
      blank_q <= 8'hFF;
      dp_q    <= '0;
    end else begin
      state_q <= state_d;
      grant_q <= grant_d;
      last_q  <= last_d;
      cnt_q   <= cnt_d;
      hex_q   <= hex_d;
      blank_q <= blank_d;
      dp_q    <= dp_d;
    end
  end
  assign grant     = grant_q;
  assign hex_out   = hex_q;
  assign blank_out = blank_q;
  assign dp_out    = dp_q;
  assign busy      = state_q == SHOW;
endmodule
